// File: rtl/sh2_ext_mem_bridge_pkg.sv
// Shared types for the SH-2 external bus to memory bridge.
//   bridge_state_t : bus-cycle FSM states
//   wb_entry_t     : one posted-write entry (full CPU address, data, active-high byte enables)
package sh2_ext_mem_bridge_pkg;

    localparam int CPU_AW = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        WR_PEND = 2'd2,
        DONE    = 2'd3
    } bridge_state_t;

    typedef struct packed {
        logic [CPU_AW-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wb_entry_t;

endpackage

// File: rtl/sh2_ext_mem_bridge_if.sv
// SH-2 external bus pins plus the req/ack memory port, bundled.
//   slave  : the bridge (consumes CPU bus, drives memory request)
//   master : the environment (CPU pins and memory controller)
interface sh2_ext_mem_bridge_if #(
    parameter int ADDR_W = 24
);
    import sh2_ext_mem_bridge_pkg::*;

    logic [CPU_AW-1:0] A;
    logic [31:0]       DO;
    logic              BS_N;
    logic [3:0]        CS_N;
    logic              RD_WR_N;
    logic [3:0]        WE_N;
    logic              RD_N;
    logic [31:0]       DI;
    logic              WAIT_N;
    logic [ADDR_W-1:0] MEM_A;
    logic [31:0]       MEM_D;
    logic [3:0]        MEM_BE;
    logic              MEM_WE;
    logic              MEM_REQ;
    logic              MEM_ACK;
    logic [31:0]       MEM_Q;

    modport slave (
        input  A, DO, BS_N, CS_N, RD_WR_N, WE_N, RD_N, MEM_ACK, MEM_Q,
        output DI, WAIT_N, MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_REQ
    );

    modport master (
        output A, DO, BS_N, CS_N, RD_WR_N, WE_N, RD_N, MEM_ACK, MEM_Q,
        input  DI, WAIT_N, MEM_A, MEM_D, MEM_BE, MEM_WE, MEM_REQ
    );

endinterface

// File: rtl/sh2_ext_mem_bridge_wbuf.sv
// One-entry posted write buffer.
//   load/load_entry : capture a write (only issued while empty)
//   ack             : memory accepted the drained entry; frees the slot
//   full            : entry valid
//   drain_req       : entry wants to go to memory
//   entry           : buffered address/data/byte enables
module sh2_wbuf
    import sh2_ext_mem_bridge_pkg::*;
(
    input  logic      CLK,
    input  logic      RST_N,
    input  logic      load,
    input  wb_entry_t load_entry,
    input  logic      ack,
    output logic      full,
    output logic      drain_req,
    output wb_entry_t entry
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= load_entry;
        end else if (ack) begin
            full  <= 1'b0;
        end
    end

    assign drain_req = full;

endmodule

// File: rtl/sh2_ext_mem_bridge.sv
// SH-2 external bus to req/ack memory bridge, one per CPU.
//   CLK, RST_N : clock, async active-low reset
//   CE_R       : CPU clock enable; bus pins only sampled when high
//   bus        : CPU pins (A/DO/BS_N/CS_N/RD_WR_N/WE_N/RD_N -> DI/WAIT_N)
//                and memory port (MEM_A/D/BE/WE/REQ -> MEM_ACK/MEM_Q)
// Selected cycles become memory requests; writes are posted through a
// one-entry buffer, reads stall the CPU with WAIT_N until data returns.
module sh2_ext_mem_bridge
    import sh2_ext_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int CS_SEL = 0,
    parameter int WB_EN  = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CE_R,
    sh2_ext_mem_bridge_if.slave bus
);

    localparam logic WB_ON = (WB_EN != 0);

    bridge_state_t     state;
    wb_entry_t         cyc, bus_entry, wb_load_entry, wb_q;
    logic              wb_full, wb_drain_req, wb_load, wb_ack;
    logic              sel, is_wr, start, post_now, rd_issue, dw_issue, own_ack;
    logic              req_drain;
    logic [31:0]       di_q, mem_d;
    logic [ADDR_W-1:0] mem_a;
    logic [3:0]        mem_be;
    logic              mem_we, mem_req;
    logic              unused_bits;

    assign sel       = !bus.CS_N[CS_SEL];
    assign is_wr     = !bus.RD_WR_N;
    assign start     = CE_R && !bus.BS_N && sel && (state == IDLE);
    assign bus_entry = '{addr: bus.A, data: bus.DO, be: ~bus.WE_N};

    // A write hitting an empty buffer is absorbed straight from IDLE so the
    // CPU never sees a wait state; WR_PEND is only for full-buffer or
    // unbuffered writes.
    assign post_now      = start && is_wr && !wb_full && WB_ON;
    assign wb_load       = post_now || ((state == WR_PEND) && WB_ON && !wb_full);
    assign wb_load_entry = (state == IDLE) ? bus_entry : cyc;

    // Reads wait for the buffer to drain: memory sees writes in program order.
    assign rd_issue = (state == RD_PEND) && !wb_full;
    assign dw_issue = (state == WR_PEND) && !WB_ON;

    assign own_ack = mem_req && bus.MEM_ACK && !req_drain;
    assign wb_ack  = mem_req && bus.MEM_ACK && req_drain;

    sh2_wbuf u_wbuf (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load       (wb_load),
        .load_entry (wb_load_entry),
        .ack        (wb_ack),
        .full       (wb_full),
        .drain_req  (wb_drain_req),
        .entry      (wb_q)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cyc       <= '0;
            di_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_a     <= '0;
            mem_d     <= '0;
            mem_be    <= '0;
            req_drain <= 1'b0;
        end else begin
            if (start) cyc <= bus_entry;

            case (state)
                IDLE:    if (start) state <= !is_wr ? RD_PEND : (post_now ? DONE : WR_PEND);
                RD_PEND: if (own_ack) begin
                             di_q  <= bus.MEM_Q;
                             state <= DONE;
                         end
                WR_PEND: if (WB_ON ? !wb_full : own_ack) state <= DONE;
                DONE:    if (CE_R && !sel) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Single outstanding request; fields frozen until ACK.
            if (mem_req) begin
                if (bus.MEM_ACK) mem_req <= 1'b0;
            end else if (rd_issue) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_be    <= 4'hF;
                mem_a     <= cyc.addr[ADDR_W-1:0];
                req_drain <= 1'b0;
            end else if (dw_issue) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_be    <= cyc.be;
                mem_a     <= cyc.addr[ADDR_W-1:0];
                mem_d     <= cyc.data;
                req_drain <= 1'b0;
            end else if (wb_drain_req) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_be    <= wb_q.be;
                mem_a     <= wb_q.addr[ADDR_W-1:0];
                mem_d     <= wb_q.data;
                req_drain <= 1'b1;
            end
        end
    end

    assign bus.WAIT_N = !(sel && (((state == IDLE) && !bus.BS_N && !(is_wr && !wb_full && WB_ON))
                                  || (state == RD_PEND) || (state == WR_PEND)));

    assign bus.DI      = di_q;
    assign bus.MEM_REQ = mem_req;
    assign bus.MEM_WE  = mem_we;
    assign bus.MEM_A   = mem_a;
    assign bus.MEM_D   = mem_d;
    assign bus.MEM_BE  = mem_be;

    // RD_N is implied by RD_WR_N; upper address bits are beyond ADDR_W.
    assign unused_bits = ^{bus.RD_N, bus.CS_N, cyc.addr, wb_q.addr};

endmodule

// File: tb/tb_sh2_ext_mem_bridge.sv
module tb_sh2_ext_mem_bridge;
    import sh2_ext_mem_bridge_pkg::*;

    localparam int CS_SEL = 0;

    typedef struct packed {
        logic        we;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } txn_t;

    logic CLK, RST_N, CE_R;
    sh2_ext_mem_bridge_if #(.ADDR_W(24)) bus ();

    sh2_ext_mem_bridge #(.ADDR_W(24), .CS_SEL(CS_SEL), .WB_EN(1)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CE_R  (CE_R),
        .bus   (bus.slave)
    );

    int n_chk = 0, n_fail = 0;
    int ack_delay = 1, n_acks = 0, force_cnt = 0, force_seen = 0;
    bit rand_delay = 0;
    txn_t exp_q[$];
    logic [31:0] rmem [logic [23:0]];   // memory contents as the controller holds them
    logic [31:0] sbmem[logic [23:0]];   // memory contents in CPU program order

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input logic [23:0] a);
        return {8'hA5, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rm_rd(input logic [23:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] sb_rd(input logic [23:0] a);
        return sbmem.exists(a) ? sbmem[a] : init_val(a);
    endfunction

    // Memory controller model: checks each request against program order,
    // holds it for a delay, then pulses MEM_ACK for one clock.
    initial begin : responder
        txn_t cur, e;
        bit busy;
        int cnt;
        busy = 0; cnt = 0; cur = '0;
        bus.MEM_ACK = 1'b0;
        bus.MEM_Q   = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                bus.MEM_ACK = 1'b0;
                busy = 0;
            end else if (bus.MEM_ACK) begin
                bus.MEM_ACK = 1'b0;
            end else if (force_cnt != force_seen) begin
                force_seen  = force_cnt;
                bus.MEM_ACK = 1'b1;
                bus.MEM_Q   = 32'hDEADBEEF;
            end else if (bus.MEM_REQ) begin
                if (!busy) begin
                    busy = 1;
                    cur  = '{we: bus.MEM_WE, a: bus.MEM_A, d: bus.MEM_D, be: bus.MEM_BE};
                    cnt  = rand_delay ? int'($urandom_range(0, 5)) : ack_delay - 1;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_req: got we=%0b a=%h be=%h, required no request", cur.we, cur.a, cur.be);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.we !== cur.we || e.a !== cur.a || e.be !== cur.be || (e.we && e.d !== cur.d)) begin
                            n_fail++;
                            $display("FAIL mem_req: got we=%0b a=%h d=%h be=%h, required we=%0b a=%h d=%h be=%h",
                                     cur.we, cur.a, cur.d, cur.be, e.we, e.a, e.d, e.be);
                        end
                    end
                end else begin
                    n_chk++;
                    if (bus.MEM_WE !== cur.we || bus.MEM_A !== cur.a || bus.MEM_BE !== cur.be || bus.MEM_D !== cur.d) begin
                        n_fail++;
                        $display("FAIL req_stable: got a=%h d=%h be=%h, required a=%h d=%h be=%h",
                                 bus.MEM_A, bus.MEM_D, bus.MEM_BE, cur.a, cur.d, cur.be);
                    end
                end
                if (cnt == 0) begin
                    bus.MEM_ACK = 1'b1;
                    busy = 0;
                    n_acks++;
                    if (cur.we) rmem[cur.a] = merge(rm_rd(cur.a), cur.d, cur.be);
                    else        bus.MEM_Q   = rm_rd(cur.a);
                end else begin
                    cnt--;
                end
            end
        end
    end

    // One CPU bus cycle with CE_R=1: strobe, then hold until WAIT_N=1.
    task automatic cpu_cycle(input bit wr, input logic [23:0] addr, input logic [31:0] data,
                             input logic [3:0] wen, input logic [3:0] cs,
                             output int waited, output logic [31:0] rdata);
        if (cs[CS_SEL] == 1'b0) begin
            exp_q.push_back('{we: wr, a: addr, d: data, be: (wr ? ~wen : 4'hF)});
            if (wr) sbmem[addr] = merge(sb_rd(addr), data, ~wen);
        end
        @(negedge CLK);
        bus.A = {3'b000, addr}; bus.DO = data; bus.RD_WR_N = !wr; bus.RD_N = wr;
        bus.WE_N = wr ? wen : 4'hF; bus.CS_N = cs; bus.BS_N = 1'b0;
        #1 waited = (bus.WAIT_N === 1'b0) ? 1 : 0;
        @(negedge CLK);
        bus.BS_N = 1'b1;
        #1;
        for (int i = 0; i < 200 && bus.WAIT_N !== 1'b1; i++) begin
            waited++;
            @(negedge CLK);
            #1;
        end
        if (bus.WAIT_N !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL cycle_timeout: WAIT_N=%b at a=%h, required release within 200 clocks", bus.WAIT_N, addr);
        end
        rdata = bus.DI;
        bus.CS_N = 4'hF; bus.RD_N = 1'b1; bus.WE_N = 4'hF; bus.RD_WR_N = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.MEM_REQ !== 1'b0); i++) begin
            @(negedge CLK);
            #1;
        end
        n_chk++;
        if (exp_q.size() != 0 || bus.MEM_REQ !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: %0d requests still owed, MEM_REQ=%b, required 0 and 0", exp_q.size(), bus.MEM_REQ);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; CE_R = 1'b1;
        bus.A = '0; bus.DO = '0; bus.BS_N = 1'b1; bus.CS_N = 4'hF;
        bus.RD_WR_N = 1'b1; bus.WE_N = 4'hF; bus.RD_N = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        n_chk++; if (bus.DI !== 32'h0)      begin n_fail++; $display("FAIL rst_di: got %h required 0", bus.DI); end
        n_chk++; if (bus.WAIT_N !== 1'b1)   begin n_fail++; $display("FAIL rst_wait: got %b required 1", bus.WAIT_N); end
        n_chk++; if (bus.MEM_A !== 24'h0)   begin n_fail++; $display("FAIL rst_mem_a: got %h required 0", bus.MEM_A); end
        n_chk++; if (bus.MEM_D !== 32'h0)   begin n_fail++; $display("FAIL rst_mem_d: got %h required 0", bus.MEM_D); end
        n_chk++; if (bus.MEM_BE !== 4'h0)   begin n_fail++; $display("FAIL rst_mem_be: got %h required 0", bus.MEM_BE); end
        n_chk++; if (bus.MEM_WE !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_we: got %b required 0", bus.MEM_WE); end
        n_chk++; if (bus.MEM_REQ !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_req: got %b required 0", bus.MEM_REQ); end
    endtask

    task automatic test_posted_write();
        int w, a0;
        logic [31:0] r;
        ack_delay = 5; rand_delay = 0; a0 = n_acks;
        cpu_cycle(1, 24'h000100, 32'h12345678, 4'h0, 4'hE, w, r);
        n_chk++; if (w != 0) begin n_fail++; $display("FAIL wr_zero_wait: got %0d waits required 0", w); end
        @(negedge CLK);
        #1;
        n_chk++;
        if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_A, bus.MEM_BE, bus.MEM_D} !== {1'b1, 1'b1, 24'h000100, 4'hF, 32'h12345678}) begin
            n_fail++;
            $display("FAIL wr_drain_req: got req=%b we=%b a=%h be=%h d=%h required 1 1 000100 f 12345678",
                     bus.MEM_REQ, bus.MEM_WE, bus.MEM_A, bus.MEM_BE, bus.MEM_D);
        end
        wait_drain();
        n_chk++; if (n_acks != a0 + 1) begin n_fail++; $display("FAIL wr_acks: got %0d required %0d", n_acks, a0 + 1); end
    endtask

    task automatic test_back_to_back();
        int w1, w2, a1;
        logic [31:0] r;
        ack_delay = 8; rand_delay = 0;
        cpu_cycle(1, 24'h000140, 32'h11111111, 4'h0, 4'hE, w1, r);
        a1 = n_acks;
        cpu_cycle(1, 24'h000144, 32'h22222222, 4'h0, 4'hE, w2, r);
        n_chk++; if (w1 != 0) begin n_fail++; $display("FAIL b2b_first_wait: got %0d required 0", w1); end
        n_chk++; if (w2 < 6)  begin n_fail++; $display("FAIL b2b_second_wait: got %0d required >=6", w2); end
        n_chk++; if (n_acks <= a1) begin n_fail++; $display("FAIL b2b_release: got acks %0d required >%0d", n_acks, a1); end
        wait_drain();
    endtask

    task automatic test_write_then_read();
        int w;
        logic [31:0] r;
        ack_delay = 4; rand_delay = 0;
        rmem[24'h000204] = 32'hCAFEF00D; sbmem[24'h000204] = 32'hCAFEF00D;
        cpu_cycle(1, 24'h000200, 32'h000000AA, 4'h0, 4'hE, w, r);
        cpu_cycle(0, 24'h000200, 32'h0, 4'hF, 4'hE, w, r);
        n_chk++; if (r !== sb_rd(24'h000200)) begin n_fail++; $display("FAIL raw_data: got %h required %h", r, sb_rd(24'h000200)); end
        n_chk++; if (w < 1) begin n_fail++; $display("FAIL rd_wait: got %0d required >=1", w); end
        cpu_cycle(0, 24'h000204, 32'h0, 4'hF, 4'hE, w, r);
        n_chk++; if (r !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rd_data: got %h required cafef00d", r); end
        wait_drain();
    endtask

    task automatic test_unselected();
        int w;
        bit saw;
        logic [31:0] r, d0;
        d0 = bus.DI;
        cpu_cycle(0, 24'h000200, 32'h0, 4'hF, 4'hD, w, r);
        n_chk++; if (w != 0 || r !== d0) begin n_fail++; $display("FAIL unsel_read: got waits=%0d di=%h required 0 %h", w, r, d0); end
        cpu_cycle(1, 24'h000208, 32'h55555555, 4'h0, 4'hD, w, r);
        n_chk++; if (w != 0) begin n_fail++; $display("FAIL unsel_write_wait: got %0d required 0", w); end
        saw = 0;
        repeat (6) begin @(negedge CLK); #1 saw |= (bus.MEM_REQ !== 1'b0); end
        n_chk++; if (saw) begin n_fail++; $display("FAIL unsel_req: got MEM_REQ activity required none"); end
    endtask

    task automatic test_spurious_ack();
        int w;
        logic [31:0] r, d0;
        wait_drain();
        d0 = bus.DI;
        force_cnt++;
        repeat (3) @(negedge CLK);
        #1;
        n_chk++;
        if (bus.MEM_REQ !== 1'b0 || bus.DI !== d0 || bus.WAIT_N !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_ack: got req=%b di=%h wait_n=%b required 0 %h 1", bus.MEM_REQ, bus.DI, bus.WAIT_N, d0);
        end
        ack_delay = 2;
        cpu_cycle(0, 24'h000200, 32'h0, 4'hF, 4'hE, w, r);
        n_chk++; if (r !== sb_rd(24'h000200)) begin n_fail++; $display("FAIL post_spurious_read: got %h required %h", r, sb_rd(24'h000200)); end
    endtask

    task automatic test_random();
        int w;
        bit wr, selected;
        logic [23:0] a;
        logic [31:0] r, d, expv;
        logic [3:0] wen;
        rand_delay = 1;
        for (int k = 0; k < 60; k++) begin
            wr = ($urandom_range(0, 2) != 0);
            selected = ($urandom_range(0, 5) != 0);
            a = 24'h000300 + 24'($urandom_range(0, 7) * 4);
            d = $urandom;
            wen = 4'($urandom_range(0, 15));
            if (wr) begin
                cpu_cycle(1, a, d, wen, selected ? 4'hE : 4'hB, w, r);
            end else begin
                expv = selected ? sb_rd(a) : bus.DI;
                cpu_cycle(0, a, 32'h0, 4'hF, selected ? 4'hE : 4'hB, w, r);
                n_chk++;
                if (r !== expv) begin
                    n_fail++;
                    $display("FAIL rand_read: a=%h sel=%0b got %h required %h", a, selected, r, expv);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        wait_drain();
        rand_delay = 0;
    endtask

    task automatic test_reset_mid();
        int w;
        bit saw;
        logic [31:0] r;
        ack_delay = 30; rand_delay = 0;
        cpu_cycle(1, 24'h0007F0, 32'h0BADF00D, 4'h0, 4'hE, w, r);
        @(negedge CLK);
        bus.A = 27'h000300; bus.RD_WR_N = 1'b1; bus.RD_N = 1'b0; bus.CS_N = 4'hE; bus.BS_N = 1'b0;
        @(negedge CLK);
        bus.BS_N = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        n_chk++;
        if (bus.MEM_REQ !== 1'b1 || bus.WAIT_N !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pending: got req=%b wait_n=%b required 1 0", bus.MEM_REQ, bus.WAIT_N);
        end
        #2 RST_N = 1'b0;
        #1;
        n_chk++;
        if (bus.MEM_REQ !== 1'b0 || bus.WAIT_N !== 1'b1 || bus.DI !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got req=%b wait_n=%b di=%h required 0 1 0", bus.MEM_REQ, bus.WAIT_N, bus.DI);
        end
        repeat (2) @(negedge CLK);
        bus.CS_N = 4'hF; bus.RD_N = 1'b1;
        exp_q.delete();
        RST_N = 1'b1;
        saw = 0;
        repeat (10) begin @(negedge CLK); #1 saw |= (bus.MEM_REQ !== 1'b0); end
        n_chk++; if (saw) begin n_fail++; $display("FAIL wb_lost: got MEM_REQ after reset required none"); end
        ack_delay = 2;
        cpu_cycle(0, 24'h000304, 32'h0, 4'hF, 4'hE, w, r);
        n_chk++; if (r !== sb_rd(24'h000304)) begin n_fail++; $display("FAIL post_reset_read: got %h required %h", r, sb_rd(24'h000304)); end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_posted_write();
        test_back_to_back();
        test_write_then_read();
        test_unselected();
        test_spurious_ack();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2ms, required completion");
        $fatal(1, "watchdog");
    end

endmodule
